pattern_sequencer: RTL
======================

// Module: pattern_sequencer
// PURPOSE
//   Upstream stage of the tracker voice: stores a pattern of 16-bit note rows
//   and steps through them at a programmable tempo, presenting one row at a time
//   on `note`. `note` connects directly to the tracker's note input.
//   Each row word is {octave[2:0], pitch[2:0], instr[1:0], volume[2:0], eff_param[2:0], eff[1:0]}.
//   A host writes the pattern through a simple write port. Play and stop are pulse controls.
// PARAMETERS
//   ROWS      64   pattern depth; must be a power of 2; row index width AW = $clog2(ROWS)
//   TICK_DIV  1024 clocks per tempo tick; must be >= 2
// PORTS
//   clk         in   1    clock; all state changes on the rising edge
//   rst         in   1    reset; asynchronous assert, active-low (0 = reset)
//   wr_en       in   1    pattern write strobe
//   wr_addr     in   AW   pattern write row
//   wr_data     in   16   pattern write word
//   play        in   1    start pulse: (re)start from row 0
//   stop        in   1    stop pulse
//   speed       in   4    ticks per row; 0 = freeze on the current row
//   loop_start  in   AW   wrap target row (used only with SEQ_LOOP_EN)
//   note        out  16   current note word to the tracker
//   row         out  AW   index of the current row
//   row_strobe  out  1    1-cycle pulse when a new row is entered
//   playing     out  1    1 while in the PLAYING state
// BEHAVIOUR
// - Reset: note=0, row=0, row_strobe=0, playing=0, and both counters cleared; pattern RAM is not cleared.
// - FSM states: STOPPED, PLAYING.
//   - STOPPED -> PLAYING on play=1 and stop=0.
//   - PLAYING -> STOPPED on stop=1, or at end of pattern when SEQ_LOOP_EN is not defined.
//   - If play and stop are both 1 in the same cycle, stop wins.
//   - play=1 while PLAYING restarts from row 0.
// - Row entry (start/restart or advance) happens at edge E:
//   - row <= new index and row_strobe=1 for the cycle after E.
//   - note <= mem[new index], unless that word is 16'h0000 ("empty row"). An empty row holds the previous note.
//   - tick_cnt and speed_cnt are cleared at E.
//   - speed is latched at E into spd_q.
// - Tempo: tick_cnt counts 0..TICK_DIV-1. On wrap, speed_cnt increments.
//   When speed_cnt reaches spd_q, the row advances.
//   Row period = spd_q*TICK_DIV clocks; the first row entry occurs at the edge after play.
// - spd_q=0 freezes the sequencer on the current row. Changing speed takes effect at the next row entry only.
//   To unfreeze, issue stop/play.
// - Stop: at the edge sampling stop=1, note <= 0 (silence) and playing <= 0. row keeps its value.
// - RAM read is combinational from the row index at entry.
//   A write at the same edge as a row entry to the same address: entry reads the OLD word.
//   Writes are allowed in any state.
// - End of pattern: occurs when row ROWS-1 expires.
// - Reset mid-play immediately forces all outputs to their reset values, with no pulse on row_strobe.
// CONFIGURATION
//   SEQ_LOOP_EN defined:
//     - At end of pattern the row wraps to loop_start, sampled at the wrap edge.
//       This is a normal row entry with row_strobe and playing stays 1.
//   SEQ_LOOP_EN undefined:
//     - At end of pattern the FSM goes to STOPPED with note<=0, playing<=0 and row=ROWS-1.
//     - loop_start is ignored.
// TESTING (ROWS=4, TICK_DIV=4)
// 1. Release rst, then idle 10 clocks -> note=0, row=0, playing=0, row_strobe never 1.
// 2. Write rows 0..3 = 16'hA1C0, 16'h0000, 16'h5280, 16'h1234. Set speed=2 and pulse play at edge P.
//    -> At P+1: row=0, note=A1C0, strobe.
//    -> At P+9: row=1, note stays A1C0 (empty row).
//    -> At P+17: row=2, note=5280.
// 3. Continue case 2 past row 3 (P+33).
//    -> Without SEQ_LOOP_EN: note=0, playing=0, row=3.
//    -> With SEQ_LOOP_EN and loop_start=1: row=1, note=1234, strobe, playing=1.
// 4. While playing, assert play and stop in the same cycle -> next edge note=0 and playing=0.
//    A later play alone -> row=0 and note=A1C0.
// 5. speed=0 at play -> row stays 0 for 200 clocks with no further strobes.
//    stop then play with speed=1 -> rows advance every 4 clocks.
// 6. Write row 2 = 16'h7777 on the same edge that row 2 is entered -> note=5280.
//    On the next visit to row 2 (SEQ_LOOP_EN, loop_start=0) -> note=7777.
// 7. Drop rst mid-row -> all outputs 0 asynchronously. After release and play, playback restarts at row 0.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Pattern sequencer: holds a pattern of 16-bit note rows and steps through them at a programmable tempo.
// Build option SEQ_LOOP_EN: at end of pattern wrap to loop_start instead of stopping.
module pattern_sequencer #(
   parameter  int ROWS     = 64,
   parameter  int TICK_DIV = 1024,
   localparam int AW       = $clog2(ROWS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic          play,
   input  logic          stop,
   input  logic [3:0]    speed,
   input  logic [AW-1:0] loop_start,
   output logic [15:0]   note,
   output logic [AW-1:0] row,
   output logic          row_strobe,
   output logic          playing
);

   localparam int TW = $clog2(TICK_DIV);

`ifdef SEQ_LOOP_EN
   localparam bit LoopEn = 1'b1;
`else
   localparam bit LoopEn = 1'b0;
`endif

   typedef enum logic {STOPPED, PLAYING} state_t;

   state_t        state_q;
   logic [15:0]   mem [ROWS];
   logic [TW-1:0] tick_q;
   logic [3:0]    speed_cnt_q;
   logic [3:0]    spd_q;
   logic [AW-1:0] row_q;
   logic [15:0]   note_q;
   logic          strobe_q;

   logic          tick_wrap;
   logic          advance;
   logic          end_of_pat;
   logic [AW-1:0] entry_idx_d;
   logic [15:0]   entry_word_d;

   // NOTE: the pattern RAM is deliberately left out of reset so it maps onto plain RAM storage.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_comb begin
      tick_wrap    = (tick_q == TW'(TICK_DIV - 1));
      advance      = (state_q == PLAYING) && (spd_q != 4'd0) && tick_wrap &&
                     ((speed_cnt_q + 4'd1) == spd_q);
      end_of_pat   = advance && (row_q == AW'(ROWS - 1));
      // loop_start is only ever used when the end-of-pattern entry is taken (looping builds)
      if (play)            entry_idx_d = '0;
      else if (end_of_pat) entry_idx_d = loop_start;
      else                 entry_idx_d = row_q + AW'(1);
      // read precedes the same-edge write, so a colliding entry sees the old word
      entry_word_d = mem[entry_idx_d];
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= STOPPED;
         row_q       <= '0;
         note_q      <= '0;
         strobe_q    <= 1'b0;
         tick_q      <= '0;
         speed_cnt_q <= '0;
         spd_q       <= '0;
      end else begin
         strobe_q <= 1'b0;
         if (stop) begin
            state_q <= STOPPED;
            note_q  <= '0;
         end else if (play || (advance && (LoopEn || !end_of_pat))) begin
            state_q     <= PLAYING;
            row_q       <= entry_idx_d;
            strobe_q    <= 1'b1;
            if (entry_word_d != 16'h0000) note_q <= entry_word_d;
            tick_q      <= '0;
            speed_cnt_q <= '0;
            spd_q       <= speed;
         end else if (advance) begin
            // last row expired without looping: silence and hold the row index
            state_q <= STOPPED;
            note_q  <= '0;
         end else if ((state_q == PLAYING) && (spd_q != 4'd0)) begin
            if (tick_wrap) begin
               tick_q      <= '0;
               speed_cnt_q <= speed_cnt_q + 4'd1;
            end else begin
               tick_q <= tick_q + TW'(1);
            end
         end
      end
   end

   assign note       = note_q;
   assign row        = row_q;
   assign row_strobe = strobe_q;
   assign playing    = (state_q == PLAYING);

endmodule
